// File: rtl/usb_rx.sv
// usb_rx: low-speed USB receiver. It covers line synchronisation, bit-clock
// recovery, NRZI decoding, SYNC detection, bit unstuffing, byte assembly and
// EOP detection.
// Optional feature: define USB_RX_ERR_CHECK_EN to report stuffing violations,
// malformed EOPs and partial bytes on 'error'. Without it, error is tied low
// and such packets end normally.
// Output protocol: valid is a one-cycle strobe qualifying data, and data holds
// until the next valid. eop and error are one-cycle strobes that never
// coincide with valid. active is high from the SYNC match until eop or error.
// There is no back-pressure, so the consumer must take each byte on valid.
package usb_rx_pkg;
  typedef struct packed {
    logic p;
    logic n;
  } d_port_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    EOP  = 2'd3
  } rx_state_t;
endpackage

module usb_rx
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  d_port_t    d,
  output logic [7:0] data,
  output logic       valid,
  output logic       active,
  output logic       eop,
  output logic       error,
  output rx_state_t  fsm_state
);
  localparam int            PW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(CLKS_PER_BIT / 2);
  localparam d_port_t       LINE_J    = 2'b01;

  d_port_t       sync1, sync2, line_q;
  logic [PW-1:0] phase;
  rx_state_t     state, state_n;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic [2:0]    ones_cnt;
  logic          prev_k;
  logic          armed;

  logic transition, strobe;
  logic is_j, is_k, is_se0, jk;
  logic nrzi_bit, stuff_bit, stuff_err;
  logic sync_last, sync_match, keep_bit, eop_end;
  logic set_active, fire_valid, fire_eop, fire_error;

  // Two-flop synchronizer plus one history flop for transition detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= LINE_J;
      sync2  <= LINE_J;
      line_q <= LINE_J;
    end else begin
      sync1  <= d;
      sync2  <= sync1;
      line_q <= sync2;
    end
  end

  // Bit-phase counter re-centred on every line transition
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (transition || phase == PH_LAST) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  assign transition = (sync2 != line_q);
  assign strobe     = (phase == PH_SAMPLE) && !transition;
  assign is_j       = !sync2.p &&  sync2.n;
  assign is_k       =  sync2.p && !sync2.n;
  assign is_se0     = !sync2.p && !sync2.n;
  assign jk         = is_j || is_k;
  // NRZI: an unchanged level decodes as 1 and a change decodes as 0.
  assign nrzi_bit   = (is_k == prev_k);
  // The sample after six decoded 1s is a stuffed bit and is never kept.
  assign stuff_bit  = (ones_cnt == 3'd6);
  assign sync_last  = strobe && jk && (bit_cnt == 3'd7);
  assign sync_match = sync_last && ({nrzi_bit, shift[7:1]} == 8'h80);
  assign keep_bit   = strobe && jk && !stuff_bit;
  assign eop_end    = strobe && jk;

`ifdef USB_RX_ERR_CHECK_EN
  logic se0_seen;
  assign stuff_err = strobe && jk && stuff_bit && nrzi_bit;

  // Remember the second SE0 of an EOP so the closing J can be validated
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      se0_seen <= 1'b0;
    end else if (state == DATA) begin
      se0_seen <= 1'b0;
    end else if (state == EOP && strobe && is_se0) begin
      se0_seen <= 1'b1;
    end
  end
`else
  assign stuff_err = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (strobe && is_k && armed) state_n = SYNC;
      SYNC: begin
        if (strobe && is_se0) state_n = IDLE;
        else if (sync_last)   state_n = sync_match ? DATA : IDLE;
      end
      DATA: begin
        if (strobe && is_se0) state_n = EOP;
        else if (stuff_err)   state_n = IDLE;
      end
      EOP:  if (eop_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // FSM output decisions, registered into the strobes below
  always_comb begin
    set_active = 1'b0;
    fire_valid = 1'b0;
    fire_eop   = 1'b0;
    fire_error = 1'b0;
    case (state)
      SYNC: set_active = sync_match;
      DATA: begin
        fire_valid = keep_bit && (bit_cnt == 3'd7);
        fire_error = stuff_err;
      end
      EOP: begin
        if (eop_end) begin
`ifdef USB_RX_ERR_CHECK_EN
          if (se0_seen && is_j && bit_cnt == 3'd0) fire_eop = 1'b1;
          else                                      fire_error = 1'b1;
`else
          fire_eop = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

  // Datapath: output strobes, byte assembly, NRZI history and idle arming
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data     <= 8'h00;
      valid    <= 1'b0;
      eop      <= 1'b0;
      error    <= 1'b0;
      active   <= 1'b0;
      shift    <= 8'h00;
      bit_cnt  <= 3'd0;
      ones_cnt <= 3'd0;
      prev_k   <= 1'b0;
      armed    <= 1'b0;
    end else begin
      valid <= fire_valid;
      eop   <= fire_eop;
      error <= fire_error;
      if (fire_valid) data <= {nrzi_bit, shift[7:1]};
      if (set_active)                active <= 1'b1;
      else if (fire_eop || fire_error) active <= 1'b0;
      if (strobe && jk) prev_k <= is_k;
      // A SYNC may only start from a J sampled while idle.
      if (state != IDLE) armed <= 1'b0;
      else if (strobe)   armed <= is_j;
      case (state)
        IDLE: begin
          if (strobe && is_k && armed) begin
            shift   <= {nrzi_bit, 7'd0};
            bit_cnt <= 3'd1;
          end
        end
        SYNC: begin
          if (strobe && jk) begin
            shift    <= {nrzi_bit, shift[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            ones_cnt <= 3'd0;
          end
        end
        DATA: begin
          if (strobe && jk) begin
            if (stuff_bit) begin
              ones_cnt <= 3'd0;
            end else begin
              shift    <= {nrzi_bit, shift[7:1]};
              bit_cnt  <= bit_cnt + 3'd1;
              ones_cnt <= nrzi_bit ? ones_cnt + 3'd1 : 3'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign fsm_state = state;
endmodule

// File: tb/tb_usb_rx.sv
// tb_usb_rx: directed and randomized packets for usb_rx. Line symbols come
// from a queue-based encoder (stuffing + NRZI). Received bytes and strobes
// are compared against the bytes that were encoded.
module tb_usb_rx;
  import usb_rx_pkg::*;

`ifdef USB_RX_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [1:0] SYM_J    = 2'b01;
  localparam logic [1:0] SYM_K    = 2'b10;
  localparam logic [1:0] SYM_SE0  = 2'b00;
  localparam logic [7:0] SYNC_OK  = 8'h80;
  localparam logic [7:0] SYNC_BAD = 8'h00;

  // clock / reset and DUT
  logic       clk = 1'b0;
  logic       reset;
  d_port_t    d;
  logic [7:0] data;
  logic       valid, active, eop, error;
  rx_state_t  fsm_state;

  usb_rx #(.CLKS_PER_BIT(16)) dut (
    .clk(clk), .reset(reset), .d(d), .data(data), .valid(valid),
    .active(active), .eop(eop), .error(error), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // scoreboard state
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic       pay_q[$];
  logic [1:0] sym_q[$];
  int checks = 0;
  int failures = 0;
  int eop_cnt = 0, err_cnt = 0, act_rise = 0;
  int overlap_cnt = 0, dbl_valid = 0, noact_valid = 0, strobe_act = 0;
  logic act_prev = 1'b0, valid_prev = 1'b0;

  // monitor, sampling on the inactive clock edge
  always @(negedge clk) begin
    if (valid) rx_q.push_back(data);
    if (eop) eop_cnt++;
    if (error) err_cnt++;
    if (active && !act_prev) act_rise++;
    if (valid && eop) overlap_cnt++;
    if (valid && valid_prev) dbl_valid++;
    if (valid && !active) noact_valid++;
    if ((eop || error) && active) strobe_act++;
    act_prev   = active;
    valid_prev = valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) pay_q.push_back(b[i]);
  endtask

  task automatic add_byte(input logic [7:0] b);
    exp_q.push_back(b);
    add_bits(b, 8);
  endtask

  // reference encoder: idle, SYNC, payload (optionally stuffed), SE0s, idle
  task automatic build(input logic [7:0] sync_pat, input bit stuff, input int n_se0);
    bit lvl;
    int ones;
    sym_q.delete();
    lvl = 1'b0;
    repeat (3) sym_q.push_back(SYM_J);
    for (int i = 0; i < 8; i++) begin
      if (!sync_pat[i]) lvl = !lvl;
      sym_q.push_back(lvl ? SYM_K : SYM_J);
    end
    ones = 0;
    foreach (pay_q[i]) begin
      if (!pay_q[i]) lvl = !lvl;
      sym_q.push_back(lvl ? SYM_K : SYM_J);
      ones = pay_q[i] ? ones + 1 : 0;
      if (stuff && ones == 6) begin
        lvl = !lvl;
        sym_q.push_back(lvl ? SYM_K : SYM_J);
        ones = 0;
      end
    end
    repeat (n_se0) sym_q.push_back(SYM_SE0);
    repeat (4) sym_q.push_back(SYM_J);
  endtask

  // driver: mode 0 = 16 clk/bit, mode 1 = alternating 15/17 clk/bit
  task automatic send(input int mode, input int limit);
    int period;
    for (int i = 0; i < sym_q.size() && i < limit; i++) begin
      period = (mode == 0) ? 16 : ((i % 2 == 0) ? 15 : 17);
      d = sym_q[i];
      repeat (period) @(negedge clk);
    end
    d = SYM_J;
  endtask

  task automatic run_packet(input string tag, input int mode, input logic [7:0] sync_pat,
                            input bit stuff, input int n_se0,
                            input int exp_eop, input int exp_err, input int exp_act);
    int rx0, eop0, err0, act0;
    logic [7:0] obs;
    rx0  = rx_q.size();
    eop0 = eop_cnt;
    err0 = err_cnt;
    act0 = act_rise;
    build(sync_pat, stuff, n_se0);
    send(mode, sym_q.size());
    repeat (40) @(negedge clk);
    check($sformatf("%s.nvalid", tag), rx_q.size() - rx0, exp_q.size());
    foreach (exp_q[i]) begin
      obs = (rx0 + i < rx_q.size()) ? rx_q[rx0 + i] : 8'hxx;
      check($sformatf("%s.byte%0d", tag, i), obs, exp_q[i]);
    end
    check($sformatf("%s.eop", tag), eop_cnt - eop0, exp_eop);
    check($sformatf("%s.error", tag), err_cnt - err0, exp_err);
    check($sformatf("%s.active_rise", tag), act_rise - act0, exp_act);
    check($sformatf("%s.active_end", tag), active, 0);
  endtask

  initial begin
    int n;
    logic [7:0] b;
    // reset block
    reset = 1'b0;
    d = SYM_J;
    repeat (5) @(negedge clk);
    check("reset.data", data, 8'h00);
    check("reset.valid", valid, 0);
    check("reset.active", active, 0);
    check("reset.eop", eop, 0);
    check("reset.error", error, 0);
    check("reset.state", 32'(fsm_state), 32'(IDLE));
    reset = 1'b1;
    repeat (40) @(negedge clk);

    exp_q.delete(); pay_q.delete(); add_byte(8'h3C);
    run_packet("p3c", 0, SYNC_OK, 1'b1, 2, 1, 0, 1);

    exp_q.delete(); pay_q.delete(); add_byte(8'hFF); add_byte(8'h7E);
    run_packet("pff7e", 0, SYNC_OK, 1'b1, 2, 1, 0, 1);

    exp_q.delete(); pay_q.delete(); add_byte(8'hA5);
    run_packet("pa5_jitter", 1, SYNC_OK, 1'b1, 2, 1, 0, 1);

    exp_q.delete(); pay_q.delete();
    run_packet("bad_sync", 0, SYNC_BAD, 1'b1, 2, 0, 0, 0);

    exp_q.delete(); pay_q.delete(); add_byte(8'h3C);
    run_packet("after_bad", 0, SYNC_OK, 1'b1, 2, 1, 0, 1);

    // sixteen raw 1s: the seventh is a stuffing violation
    exp_q.delete(); pay_q.delete();
    add_bits(8'hFF, 8); add_bits(8'hFF, 8);
    if (!ERR_EN) exp_q.push_back(8'hFF);
    run_packet("stuff_viol", 0, SYNC_OK, 1'b0, 2, ERR_EN ? 0 : 1, ERR_EN ? 1 : 0, 1);

    // one full byte plus three dangling bits at EOP
    exp_q.delete(); pay_q.delete(); add_byte(8'h5A); add_bits(8'h05, 3);
    run_packet("partial", 0, SYNC_OK, 1'b1, 2, ERR_EN ? 0 : 1, ERR_EN ? 1 : 0, 1);

    // single-SE0 EOP
    exp_q.delete(); pay_q.delete(); add_byte(8'h96);
    run_packet("short_eop", 0, SYNC_OK, 1'b1, 1, ERR_EN ? 0 : 1, ERR_EN ? 1 : 0, 1);

    // asynchronous reset four bits into a byte
    exp_q.delete(); pay_q.delete(); add_byte(8'hC3);
    build(SYNC_OK, 1'b1, 2);
    send(0, 3 + 8 + 4);
    check("rst_mid.active_before", active, 1);
    #3 reset = 1'b0;
    #1;
    check("rst_mid.data", data, 8'h00);
    check("rst_mid.valid", valid, 0);
    check("rst_mid.active", active, 0);
    check("rst_mid.eop", eop, 0);
    check("rst_mid.error", error, 0);
    check("rst_mid.state", 32'(fsm_state), 32'(IDLE));
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (64) @(negedge clk);
    exp_q.delete(); pay_q.delete(); add_byte(8'hC3);
    run_packet("after_rst", 0, SYNC_OK, 1'b1, 2, 1, 0, 1);

    // randomized packets, biased towards 8'hFF to exercise stuffing
    for (int r = 0; r < 6; r++) begin
      exp_q.delete(); pay_q.delete();
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
        add_byte(b);
      end
      run_packet($sformatf("rnd%0d", r), $urandom_range(0, 1), SYNC_OK, 1'b1, 2, 1, 0, 1);
    end

    // whole-run protocol properties
    check("valid_eop_overlap", overlap_cnt, 0);
    check("valid_wider_than_1", dbl_valid, 0);
    check("valid_without_active", noact_valid, 0);
    check("active_at_end_strobe", strobe_act, 0);
    check("total_error", err_cnt, ERR_EN ? 3 : 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/usb_rx.md
USB_RX -- requirements
Module: usb_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per low-speed bit (24 MHz / 1.5 Mbit/s).
REQ-002 SHALL have port clk, input, 1, system clock, 24 MHz.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port d, input, d_port_t (2), raw USB line {p,n}; J = p0/n1, K = p1/n0, SE0 = p0/n0.
REQ-005 SHALL have port data, output, 8, received byte, LSB received first.
REQ-006 SHALL have port valid, output, 1, one-cycle strobe qualifying data.
REQ-007 SHALL have port active, output, 1, high from SYNC match until EOP or abort.
REQ-008 SHALL have port eop, output, 1, one-cycle strobe at the end of a packet.
REQ-009 SHALL have port error, output, 1, one-cycle strobe on a receive error.

Function
REQ-010 SHALL pass d through a 2-flop synchronizer before any other use.
REQ-011 SHALL recover bit timing with a mod-CLKS_PER_BIT phase counter cleared on every synchronized line transition; sample strobe at phase CLKS_PER_BIT/2.
REQ-012 SHALL NRZI-decode each sampled J/K: same as previous sample = 1, different = 0.
REQ-013 SHALL use FSM states IDLE, SYNC, DATA, EOP.
REQ-014 In IDLE, on the first J-to-K transition, SHALL go to SYNC.
REQ-015 In SYNC, on decoded pattern 0000_0001 (KJKJKJKK), SHALL go to DATA and assert active the next cycle; any other 8-bit pattern or SE0 SHALL return to IDLE silently.
REQ-016 In DATA, SHALL discard the bit following six consecutive decoded 1s (bit unstuffing); the counter resets on every 0 and on every discarded bit.
REQ-017 SHALL shift unstuffed bits LSB first and, on the 8th, drive data and pulse valid exactly one cycle after that sample strobe.
REQ-018 In DATA, on an SE0 sample, SHALL go to EOP; in EOP, a second SE0 sample followed by a J sample SHALL pulse eop, deassert active in the same cycle, and return to IDLE.
REQ-019 EOP with a partial byte (1-7 bits) pending SHALL discard the bits without pulsing valid.
REQ-020 A single SE0 sample followed by J or K SHALL be treated as an error (REQ-024 or REQ-026).
REQ-021 valid and eop SHALL never pulse in the same cycle; eop SHALL follow the last valid by at least 1 cycle.
REQ-022 data SHALL hold its last value until the next valid.

Reset
REQ-023 While reset is low: FSM = IDLE; data = 8'h00; valid, active, eop, error = 0; synchronizer flops = J; counters = 0; effective immediately and asynchronously, including mid-packet; released operation SHALL wait for idle J before accepting SYNC.

Configuration
REQ-024 Macro USB_RX_ERR_CHECK_EN defined: seventh consecutive 1 (stuff violation), malformed EOP, or partial byte at EOP SHALL pulse error, deassert active, suppress eop, and return to IDLE (partial-byte case: error replaces eop).
REQ-025 With USB_RX_ERR_CHECK_EN defined, error SHALL be asserted one cycle after the offending sample strobe.
REQ-026 Macro undefined: error SHALL be tied 0; stuff violations SHALL drop the bit and continue; malformed/partial EOP SHALL end the packet normally with eop.

Verification
REQ-027 Idle J, SYNC, byte 8'h3C, valid EOP -> one valid with data=8'h3C, then eop; active high throughout; error never set.
REQ-028 SYNC, bytes 8'hFF, 8'h7E (stuffed bits inserted), EOP -> valid twice with 8'hFF then 8'h7E; no error.
REQ-029 SYNC, 8'hA5 with bit period alternating 15/17 clk cycles -> data=8'hA5 received correctly.
REQ-030 SYNC, seven consecutive unstuffed 1s -> with USB_RX_ERR_CHECK_EN: error pulse, active drops, no eop; without: error stays 0, packet continues.
REQ-031 Corrupted SYNC KJKJKJKJ -> no active, no valid; following correct packet with 8'h3C received normally.
REQ-032 reset asserted after 4 bits of a data byte -> all outputs 0 immediately; after release, next packet with 8'hC3 received correctly.
